// File: rtl/maxhpc_fifo_drain.sv
// Read-side drain for a normal-mode FIFO: issues rd strobes on credit, absorbs
// the fixed read latency in a skid buffer and presents a valid/ready stream.
module maxhpc_fifo_drain #(
  parameter int DATA_WD = 8,
  parameter int RD_LAT  = 2   // 1 (FIFO output register off) or 2 (on)
) (
  input  logic                        clock,
  input  logic                        clear_n,
  output logic                        f_rd,
  input  logic [DATA_WD-1:0]          f_q,
  input  logic                        f_rempty,
  input  logic                        flush,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WD-1:0]          m_data,
  output logic [$clog2(RD_LAT+3)-1:0] level
);
  localparam int SKID_DEPTH = RD_LAT + 2;
  localparam int LVL_W      = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W      = $clog2(SKID_DEPTH);

  logic [RD_LAT-1:0]  vld_pipe;
  logic [LVL_W-1:0]   inflight;
  logic [LVL_W-1:0]   count;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [DATA_WD-1:0] mem [SKID_DEPTH];
  logic               ret;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + LVL_W'(vld_pipe[i]);
  end

  // Credit covers both buffered words and reads whose data has not landed yet,
  // so the skid buffer can never overflow even with m_ready held low.
  assign f_rd = clear_n && !f_rempty && !flush &&
                (({1'b0, inflight} + {1'b0, count}) < (LVL_W + 1)'(SKID_DEPTH));

  assign ret     = vld_pipe[RD_LAT-1];
  assign push    = ret && !flush;
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rptr];
  assign level   = count;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= f_rd;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= f_q;
    end
  end

endmodule
